// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master bridge.
// Latency / backpressure: none (declarations only).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: cleared on load_i, advances on count_i, saturates at the last cycle.
// Latency: expire_o is combinational during the TIMEOUT_CYCLES-th counted cycle; no backpressure.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 master; one transfer in flight. Optional ACCESS timeout: APB_TIMEOUT_EN.
// Latency: accept N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 (zero-wait); cmd_ready low until response is taken.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  apb_state_e        state_q, state_d;
  logic              ready_en_q;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              accept;
  logic              tmo_expire;

  // ready_en_q keeps cmd_ready low while reset is asserted and for the first cycle after.
  assign cmd_ready = ready_en_q &
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;

    case (state_q)
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (Pready || tmo_expire) begin
          state_d      = RESP;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = Pready ? Pslverr : 1'b1;
          rsp_rdata_d  = (Pready && !Pslverr && !pwrite_q) ? Prdata : '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_slverr_d = 1'b0;
          rsp_rdata_d  = '0;
        end
      end
      default: ;
    endcase

    // Accept can only fire in IDLE or on a RESP handshake, so it overrides the case above.
    if (accept) begin
      if (is_misaligned(cmd_addr[1:0])) begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_slverr_d = 1'b1;
        rsp_rdata_d  = '0;
      end else begin
        state_d   = SETUP;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = cmd_write;
        paddr_d   = cmd_addr;
        pwdata_d  = cmd_wdata;
      end
    end
  end

  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      state_q      <= IDLE;
      ready_en_q   <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i   (Pclk),
    .rst_n_i (Preset),
    .load_i  (state_q == SETUP),
    .count_i (state_q == ACCESS),
    .expire_o(tmo_expire)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_expire     = 1'b0;
`endif

  assign Psel       = psel_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, hand sequences, random traffic vs a memory model.
module tb_apb_master_bridge;

  logic        Pclk = 1'b0;
  logic        Preset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        Psel, Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] Prdata = '0;
  logic        Pready = 1'b0;
  logic        Pslverr = 1'b0;

  apb_master_bridge dut (
    .Pclk(Pclk), .Preset(Preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  // APB slave with its own memory, filled only from what it sees on the bus.
  int          slv_waits = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_mem [logic [31:0]];
  int          acc_cnt = 0;
  logic [31:0] su_addr = '0, su_wdata = '0;
  logic        su_wr = 1'b0;

  always @(posedge Pclk) begin
    #1;
    if (Psel && !Penable) begin
      su_addr  = Paddr;
      su_wdata = Pwdata;
      su_wr    = Pwrite;
    end
    if (Psel && Penable) begin
      chk("paddr_stable", Paddr, su_addr);
      chk("pwdata_stable", Pwdata, su_wdata);
      chk("pwrite_stable", {31'b0, Pwrite}, {31'b0, su_wr});
      Pready  = (acc_cnt == slv_waits);
      Pslverr = Pready && slv_err;
      Prdata  = $urandom;
      if (Pready && !Pwrite) Prdata = slv_mem.exists(Paddr) ? slv_mem[Paddr] : 32'h0;
      if (Pready && Pwrite && !slv_err) slv_mem[Paddr] = Pwdata;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      Pready  = 1'b0;
      Pslverr = 1'b0;
      Prdata  = $urandom;
    end
  end

  // Issue one command, act as the response consumer, and measure cycle offsets from acceptance.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int waits, input logic err, input int rsp_dly,
                     output logic [31:0] rdata, output logic serr,
                     output int lat_psel, output int lat_rsp, output int n_pen);
    int  bound;
    bit  done;
    slv_waits = waits;
    slv_err   = err;
    lat_psel  = -1;
    lat_rsp   = -1;
    n_pen     = 0;
    rdata     = 32'hxxxx_xxxx;
    serr      = 1'bx;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    bound = 0;
    while (!cmd_ready && bound < 50) begin
      step();
      bound++;
    end
    if (!cmd_ready) begin
      chk("accept_wait", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    for (int k = 1; k < 200 && !done; k++) begin
      if (Psel && lat_psel < 0) lat_psel = k;
      if (Penable) n_pen++;
      if (rsp_valid) begin
        lat_rsp = k;
        rdata   = rsp_rdata;
        serr    = rsp_slverr;
        for (int d = 0; d < rsp_dly; d++) begin
          step();
          chk("rsp_hold", {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        done = 1'b1;
      end else begin
        step();
      end
    end
    if (!done) chk("rsp_wait", {31'b0, rsp_valid}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_serr;
    int          exp_psel;
    int          exp_rsp;
    int          exp_npen;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v, input int rsp_dly);
    logic [31:0] rd;
    logic        se;
    int          lp, lr, np;
    txn(v.wr, v.addr, v.wdata, v.waits, v.err, rsp_dly, rd, se, lp, lr, np);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_slverr"}, {31'b0, se}, {31'b0, v.exp_serr});
    chk({tag, "_psel_lat"}, 32'(lp), 32'(v.exp_psel));
    chk({tag, "_rsp_lat"}, 32'(lr), 32'(v.exp_rsp));
    chk({tag, "_penable_cycles"}, 32'(np), 32'(v.exp_npen));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_slverr"}, {31'b0, rsp_slverr}, 32'd0);
    chk({tag, "_psel"}, {31'b0, Psel}, 32'd0);
    chk({tag, "_penable"}, {31'b0, Penable}, 32'd0);
    chk({tag, "_pwrite"}, {31'b0, Pwrite}, 32'd0);
    chk({tag, "_paddr"}, Paddr, 32'd0);
    chk({tag, "_pwdata"}, Pwdata, 32'd0);
  endtask

  // Reference model: a word memory updated by successful aligned writes.
  logic [31:0] model_mem [logic [31:0]];

  function automatic vec_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.err = err;
    if (addr[1:0] != 2'b00) begin
      v.exp_rdata = 0; v.exp_serr = 1'b1; v.exp_psel = -1; v.exp_rsp = 1; v.exp_npen = 0;
    end else begin
      v.exp_psel = 1;
      v.exp_npen = waits + 1;
      v.exp_rsp  = waits + 3;
      v.exp_serr = err;
      v.exp_rdata = 0;
      if (!wr && !err) v.exp_rdata = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
      if (wr && !err) model_mem[addr] = wdata;
    end
    return v;
  endfunction

  vec_t vt [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h10, 32'hA5A5_0001, 0,  1'b0, 32'h0,         1'b0, 1,  3,  1};
    vt[1]  = '{1'b1, 32'h20, 32'h1234_5678, 1,  1'b0, 32'h0,         1'b0, 1,  4,  2};
    vt[2]  = '{1'b0, 32'h20, 32'h0,         3,  1'b0, 32'h1234_5678, 1'b0, 1,  6,  4};
    vt[3]  = '{1'b1, 32'h24, 32'hDEAD_BEEF, 0,  1'b0, 32'h0,         1'b0, 1,  3,  1};
    vt[4]  = '{1'b0, 32'h24, 32'h0,         0,  1'b1, 32'h0,         1'b1, 1,  3,  1};
    vt[5]  = '{1'b0, 32'h13, 32'h0,         0,  1'b0, 32'h0,         1'b1, -1, 1,  0};
    vt[6]  = '{1'b0, 32'h10, 32'h0,         2,  1'b0, 32'hA5A5_0001, 1'b0, 1,  5,  3};
    vt[7]  = '{1'b1, 32'h30, 32'h55AA_55AA, 0,  1'b1, 32'h0,         1'b1, 1,  3,  1};
    vt[8]  = '{1'b0, 32'h30, 32'h0,         0,  1'b0, 32'h0,         1'b0, 1,  3,  1};
    vt[9]  = '{1'b0, 32'h40, 32'h0,         15, 1'b0, 32'h0,         1'b0, 1,  18, 16};
    vt[10] = '{1'b1, 32'h16, 32'hFFFF_0000, 0,  1'b0, 32'h0,         1'b1, -1, 1,  0};

    // Reset state
    #12;
    chk_outputs_zero("reset");
    @(negedge Pclk);
    Preset = 1'b1;
    step();
    chk("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vt[i], i % 2);

    // Back-to-back: second command waits on the response handshake, then SETUP next cycle.
    slv_waits = 0; slv_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h1111_2222;
    chk("b2b_ready0", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_write = 1'b0; cmd_addr = 32'h60; cmd_wdata = 32'h0; rsp_ready = 1'b1;
    chk("b2b_setup_ready", {31'b0, cmd_ready}, 32'd0);
    chk("b2b_setup_psel", {31'b0, Psel}, 32'd1);
    chk("b2b_setup_pwrite", {31'b0, Pwrite}, 32'd1);
    step();
    chk("b2b_access_pen", {31'b0, Penable}, 32'd1);
    step();
    chk("b2b_rsp1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rsp1_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("b2b_rsp1_slverr", {31'b0, rsp_slverr}, 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("b2b_setup2_psel", {31'b0, Psel}, 32'd1);
    chk("b2b_setup2_pen", {31'b0, Penable}, 32'd0);
    chk("b2b_setup2_pwrite", {31'b0, Pwrite}, 32'd0);
    chk("b2b_setup2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    chk("b2b_access2_pen", {31'b0, Penable}, 32'd1);
    step();
    chk("b2b_rsp2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h1111_2222);
    step();
    rsp_ready = 1'b0;
    chk("b2b_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);

`ifdef APB_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{1'b0, 32'h44, 32'h0, 1000, 1'b0, 32'h0, 1'b1, 1, 18, 16};
      run_vec("timeout", tv, 0);
      chk("timeout_psel_after", {31'b0, Psel}, 32'd0);
    end
`endif

    // Random traffic against the memory model, in an address window the directed vectors leave alone.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      vec_t        v;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      v = model(1'($urandom), a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      run_vec($sformatf("rnd%0d", i), v, $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of ACCESS.
    slv_waits = 1000; slv_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("rst_mid_in_access", {31'b0, Penable}, 32'd1);
    chk("rst_mid_paddr", Paddr, 32'h50);
    #2;
    Preset = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    @(negedge Pclk);
    Preset = 1'b1;
    slv_waits = 0;
    step();
    chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
